// File: rtl/acc_drain_pkg.sv
// Shared configuration and types for the accumulator drain path.
// Array geometry and row-FIFO depth live here so every stage agrees on them.
package Config;

    localparam int unsigned sys_cols       = 4;
    localparam int unsigned P_BITWIDTH     = 32;
    localparam int unsigned ACC_FIFO_DEPTH = 8;

    typedef logic [sys_cols-1:0][P_BITWIDTH-1:0] row_t;

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        FLUSH,
        WAIT_EMPTY
    } drain_state_t;

endpackage

// File: rtl/acc_drain_if.sv
// Row handshake between the drain block and the output writer.
interface acc_drain_if;
    import Config::*;

    logic o_valid;
    logic o_ready;
    row_t o_data;

    modport master (output o_valid, output o_data, input o_ready);
    modport slave  (input o_valid, input o_data, output o_ready);

endinterface

// File: rtl/acc_drain_row_fifo.sv
// Show-ahead row FIFO; a push into a full FIFO succeeds when a pop happens on the same edge.
module row_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Extra pointer bit tells full from empty when the indices match.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/acc_drain.sv
// Realigns the skewed accumulator column stream into whole rows, buffers them and
// offers them downstream with optional ReLU; pulses drain_done once a tile has left.
module acc_drain
    import Config::*;
#(
    parameter int unsigned FIFO_DEPTH = ACC_FIFO_DEPTH
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [sys_cols-1:0]                  read_out,
    input  logic [sys_cols-1:0][P_BITWIDTH-1:0]  i_data,
    input  logic                                 acc_done,
    input  logic                                 relu_en,
    acc_drain_if.master                          dn,
    output logic [15:0]                          row_count,
    output logic                                 drain_done,
    output logic                                 overflow,
    output logic                                 deskew_err
);

    localparam int unsigned FW = $clog2(sys_cols) + 1;

    logic [sys_cols-1:0] dsk_v;
    logic [sys_cols-1:0] in_flight;
    row_t                dsk_d;
    row_t                head;
    logic                row_v;
    logic                pending;
    logic                pop_fire;
    logic                fifo_full;
    logic                fifo_empty;
    drain_state_t        state;
    logic [FW-1:0]       flush_cnt;

    // Column c is delayed sys_cols-1-c cycles so all columns of a row line up.
    for (genvar c = 0; c < sys_cols; c++) begin : g_col
        localparam int unsigned D  = sys_cols - 1 - c;
        localparam int unsigned DW = D * P_BITWIDTH;
        if (D == 0) begin : g_pass
            assign dsk_v[c]     = read_out[c];
            assign dsk_d[c]     = i_data[c];
            assign in_flight[c] = 1'b0;
        end else begin : g_dly
            logic [D-1:0]                 v_sr;
            logic [D-1:0][P_BITWIDTH-1:0] d_sr;

            always_ff @(posedge clk) begin
                if (rst) v_sr <= '0;
                else     v_sr <= D'({v_sr, read_out[c]});
            end

            always_ff @(posedge clk) begin
                d_sr <= DW'({d_sr, i_data[c]});
            end

            assign dsk_v[c]     = v_sr[D-1];
            assign dsk_d[c]     = d_sr[D-1];
            assign in_flight[c] = |v_sr;
        end
    end

    assign row_v    = dsk_v[0];
    assign pending  = row_v | (|in_flight);
    assign pop_fire = dn.o_valid && dn.o_ready;

    row_fifo #(
        .WIDTH ($bits(row_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (row_v),
        .wdata (dsk_d),
        .pop   (pop_fire),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign dn.o_valid = !fifo_empty;

    for (genvar c = 0; c < sys_cols; c++) begin : g_relu
        assign dn.o_data[c] = (relu_en && head[c][P_BITWIDTH-1]) ? '0 : head[c];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            overflow   <= 1'b0;
            deskew_err <= 1'b0;
        end else begin
            if (row_v && fifo_full && !pop_fire)  overflow   <= 1'b1;
            if (dsk_v != {sys_cols{row_v}})       deskew_err <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            flush_cnt  <= '0;
            row_count  <= '0;
            drain_done <= 1'b0;
        end else begin
            drain_done <= 1'b0;
            if (pop_fire) row_count <= row_count + 16'd1;
            case (state)
                IDLE: begin
                    // A new tile restarts the count; acc_done alone means an empty tile.
                    if (read_out[0]) row_count <= '0;
                    if (acc_done) begin
                        state     <= FLUSH;
                        flush_cnt <= FW'(sys_cols - 1);
                    end else if (read_out[0]) begin
                        state <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (acc_done) begin
                        state     <= FLUSH;
                        flush_cnt <= FW'(sys_cols - 1);
                    end
                end
                FLUSH: begin
                    if (flush_cnt == '0) state     <= WAIT_EMPTY;
                    else                 flush_cnt <= flush_cnt - 1'b1;
                end
                WAIT_EMPTY: begin
                    if (fifo_empty && !pending) begin
                        drain_done <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_acc_drain.sv
// Directed bench for acc_drain: sys_cols=4, P_BITWIDTH=32, FIFO depth 8.
`timescale 1ns/1ps
module tb_acc_drain;
    import Config::*;

    logic          clk = 1'b0;
    logic          rst;
    logic [3:0]    read_out;
    row_t          i_data;
    logic          acc_done;
    logic          relu_en;
    logic [15:0]   row_count;
    logic          drain_done;
    logic          overflow;
    logic          deskew_err;

    acc_drain_if dn ();

    acc_drain #(.FIFO_DEPTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .read_out   (read_out),
        .i_data     (i_data),
        .acc_done   (acc_done),
        .relu_en    (relu_en),
        .dn         (dn),
        .row_count  (row_count),
        .drain_done (drain_done),
        .overflow   (overflow),
        .deskew_err (deskew_err)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_pass   = 0;
    row_t        got[$];
    int unsigned got_cyc[$];
    int unsigned dd_cnt  = 0;
    int unsigned cyc_cnt = 0;
    row_t        row_in [16];
    int          skip_r = -1;
    int          skip_c = -1;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    always @(negedge clk) begin
        if (dn.o_valid && dn.o_ready) begin
            got.push_back(dn.o_data);
            got_cyc.push_back(cyc_cnt);
        end
        if (drain_done) dd_cnt++;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc();
    endtask

    // Step k of a skewed burst of n rows: column c carries row k-c.
    task automatic drive_step(input int n, input int k);
        for (int c = 0; c < 4; c++) begin
            int r;
            r = k - c;
            if (r >= 0 && r < n && !(r == skip_r && c == skip_c)) begin
                read_out[2'(c)] = 1'b1;
                i_data[2'(c)]   = row_in[4'(r)][2'(c)];
            end else begin
                read_out[2'(c)] = 1'b0;
                i_data[2'(c)]   = '0;
            end
        end
    endtask

    task automatic send_rows(input int n, input int stop);
        for (int k = 0; k < stop; k++) begin
            drive_step(n, k);
            cyc();
        end
        read_out = '0;
        i_data   = '0;
    endtask

    task automatic fill_rows(input int unsigned seed);
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 4; c++)
                row_in[4'(r)][2'(c)] = 32'(seed + 16 * r + c);
    endtask

    task automatic wait_pops(input int base, input int n, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (got.size() - base >= n) break;
            cyc();
        end
    endtask

    task automatic check_order(input string name, input int base, input int n);
        int errs;
        errs = 0;
        for (int i = 0; i < n; i++) begin
            if (base + i >= got.size()) errs++;
            else if (got[base + i] !== row_in[4'(i)]) errs++;
        end
        n_checks++; if (errs != 0) $display("FAIL %s: %0d rows wrong or missing, expected 0", name, errs); else n_pass++;
    endtask

    task automatic finish_tile(input string name);
        int          lat;
        int unsigned d0;
        lat = -1;
        d0  = dd_cnt;
        acc_done = 1'b1;
        cyc();
        acc_done = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (drain_done) begin
                lat = i;
                break;
            end
            @(posedge clk);
            #1;
        end
        idle(5);
        n_checks++; if (lat < 4) $display("FAIL %s_drain_latency: got %0d cycles expected >= 4 (-1 = none)", name, lat); else n_pass++;
        n_checks++; if (dd_cnt - d0 != 1) $display("FAIL %s_drain_pulses: got %0d expected 1", name, dd_cnt - d0); else n_pass++;
    endtask

    task automatic test_reset();
        rst = 1'b1; read_out = '0; i_data = '0; acc_done = 1'b0; relu_en = 1'b0; dn.o_ready = 1'b0;
        idle(3);
        n_checks++; if (dn.o_valid !== 1'b0) $display("FAIL reset_o_valid: got %b expected 0", dn.o_valid); else n_pass++;
        n_checks++; if (drain_done !== 1'b0) $display("FAIL reset_drain_done: got %b expected 0", drain_done); else n_pass++;
        n_checks++; if (overflow !== 1'b0) $display("FAIL reset_overflow: got %b expected 0", overflow); else n_pass++;
        n_checks++; if (deskew_err !== 1'b0) $display("FAIL reset_deskew_err: got %b expected 0", deskew_err); else n_pass++;
        n_checks++; if (row_count !== 16'd0) $display("FAIL reset_row_count: got %0d expected 0", row_count); else n_pass++;
        rst = 1'b0;
        idle(2);
    endtask

    task automatic test_single_row();
        logic [7:0] ov;
        row_t       d4;
        int         base;
        row_in[0] = {32'd4, 32'd3, 32'd2, 32'd1};
        dn.o_ready = 1'b1;
        base = got.size();
        ov = '0;
        d4 = '0;
        for (int k = 0; k < 8; k++) begin
            drive_step(1, k);
            @(negedge clk);
            ov = {ov[6:0], dn.o_valid};
            if (k == 4) d4 = dn.o_data;
            cyc();
        end
        n_checks++; if (ov !== 8'b0000_1000) $display("FAIL single_valid_timing: got %b expected 00001000 (bit7 = t+0)", ov); else n_pass++;
        n_checks++; if (d4 !== row_in[0]) $display("FAIL single_data: got %h expected %h", d4, row_in[0]); else n_pass++;
        n_checks++; if (got.size() - base != 1) $display("FAIL single_pops: got %0d expected 1", got.size() - base); else n_pass++;
        n_checks++; if (row_count !== 16'd1) $display("FAIL single_row_count: got %0d expected 1", row_count); else n_pass++;
        finish_tile("single");
    endtask

    task automatic test_streaming();
        int base;
        fill_rows(1000);
        dn.o_ready = 1'b1;
        base = got.size();
        send_rows(16, 19);
        idle(6);
        n_checks++; if (got.size() - base != 16) $display("FAIL stream_pops: got %0d expected 16", got.size() - base); else n_pass++;
        check_order("stream_order", base, 16);
        if (got.size() - base >= 16) begin
            n_checks++; if (got_cyc[base + 15] - got_cyc[base] != 15) $display("FAIL stream_back_to_back: span %0d expected 15", got_cyc[base + 15] - got_cyc[base]); else n_pass++;
        end
        n_checks++; if (row_count !== 16'd16) $display("FAIL stream_row_count: got %0d expected 16", row_count); else n_pass++;
        n_checks++; if (overflow !== 1'b0 || deskew_err !== 1'b0) $display("FAIL stream_flags: got ovf=%b dsk=%b expected 0 0", overflow, deskew_err); else n_pass++;
        finish_tile("stream");
    endtask

    task automatic test_overflow();
        int base;
        fill_rows(2000);
        dn.o_ready = 1'b0;
        base = got.size();
        send_rows(10, 13);
        idle(3);
        n_checks++; if (overflow !== 1'b1) $display("FAIL ovf_flag: got %b expected 1", overflow); else n_pass++;
        n_checks++; if (dn.o_valid !== 1'b1 || dn.o_data !== row_in[0]) $display("FAIL ovf_head: got v=%b %h expected 1 %h", dn.o_valid, dn.o_data, row_in[0]); else n_pass++;
        dn.o_ready = 1'b1;
        wait_pops(base, 8, 30);
        idle(4);
        n_checks++; if (got.size() - base != 8) $display("FAIL ovf_pops: got %0d expected 8", got.size() - base); else n_pass++;
        check_order("ovf_order", base, 8);
        n_checks++; if (row_count !== 16'd8) $display("FAIL ovf_row_count: got %0d expected 8", row_count); else n_pass++;
        finish_tile("ovf");
    endtask

    task automatic test_full_push_pop();
        int base;
        n_checks++; if (overflow !== 1'b1) $display("FAIL full_ovf_sticky: got %b expected 1", overflow); else n_pass++;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        n_checks++; if (overflow !== 1'b0) $display("FAIL full_ovf_cleared: got %b expected 0", overflow); else n_pass++;
        fill_rows(3000);
        dn.o_ready = 1'b0;
        base = got.size();
        fork
            send_rows(9, 12);
            begin
                idle(11);
                dn.o_ready = 1'b1;
                cyc();
                dn.o_ready = 1'b0;
            end
        join
        n_checks++; if (got.size() - base != 1) $display("FAIL full_single_pop: got %0d expected 1", got.size() - base); else n_pass++;
        n_checks++; if (overflow !== 1'b0) $display("FAIL full_no_drop: got %b expected 0", overflow); else n_pass++;
        n_checks++; if (dn.o_data !== row_in[1]) $display("FAIL full_head: got %h expected %h", dn.o_data, row_in[1]); else n_pass++;
        dn.o_ready = 1'b1;
        wait_pops(base, 9, 30);
        idle(3);
        n_checks++; if (got.size() - base != 9) $display("FAIL full_total_pops: got %0d expected 9", got.size() - base); else n_pass++;
        check_order("full_order", base, 9);
        finish_tile("full");
    endtask

    task automatic test_relu();
        int   base;
        row_t exp0;
        row_t exp1;
        row_in[0] = {32'hFFFF_FFFF, 32'd0, 32'd7, 32'hFFFF_FFFB};
        row_in[1] = {32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'd3};
        exp0      = {32'd0, 32'd0, 32'd7, 32'd0};
        exp1      = {32'd0, 32'h7FFF_FFFF, 32'd0, 32'd3};
        relu_en = 1'b1;
        dn.o_ready = 1'b1;
        base = got.size();
        send_rows(2, 5);
        idle(5);
        n_checks++; if (got.size() - base != 2) $display("FAIL relu_pops: got %0d expected 2", got.size() - base); else n_pass++;
        if (got.size() - base >= 2) begin
            n_checks++; if (got[base] !== exp0) $display("FAIL relu_row0: got %h expected %h", got[base], exp0); else n_pass++;
            n_checks++; if (got[base + 1] !== exp1) $display("FAIL relu_row1: got %h expected %h", got[base + 1], exp1); else n_pass++;
        end
        n_checks++; if (row_count !== 16'd2) $display("FAIL relu_row_count: got %0d expected 2", row_count); else n_pass++;
        finish_tile("relu");
        relu_en = 1'b0;
        base = got.size();
        send_rows(1, 4);
        idle(5);
        n_checks++; if (got.size() - base != 1 || got[base] !== row_in[0]) $display("FAIL relu_off_raw: got %0d rows %h expected 1 %h", got.size() - base, (got.size() > base) ? got[base] : '0, row_in[0]); else n_pass++;
        finish_tile("relu_off");
    endtask

    task automatic test_reset_mid_tile();
        int          base;
        int unsigned d0;
        fill_rows(4000);
        dn.o_ready = 1'b1;
        base = got.size();
        send_rows(6, 5);
        n_checks++; if (dn.o_valid !== 1'b1 || row_count !== 16'd1) $display("FAIL midrst_pre: got v=%b cnt=%0d expected 1 1", dn.o_valid, row_count); else n_pass++;
        d0 = dd_cnt;
        rst = 1'b1;
        dn.o_ready = 1'b0;
        cyc();
        rst = 1'b0;
        dn.o_ready = 1'b1;
        n_checks++; if (dn.o_valid !== 1'b0) $display("FAIL midrst_o_valid: got %b expected 0", dn.o_valid); else n_pass++;
        n_checks++; if (row_count !== 16'd0) $display("FAIL midrst_row_count: got %0d expected 0", row_count); else n_pass++;
        idle(15);
        n_checks++; if (dd_cnt != d0) $display("FAIL midrst_no_drain: got %0d pulses expected 0", dd_cnt - d0); else n_pass++;
        n_checks++; if (got.size() - base != 1 || dn.o_valid !== 1'b0) $display("FAIL midrst_discard: got %0d pops v=%b expected 1 0", got.size() - base, dn.o_valid); else n_pass++;
        n_checks++; if (overflow !== 1'b0 || deskew_err !== 1'b0) $display("FAIL midrst_flags: got ovf=%b dsk=%b expected 0 0", overflow, deskew_err); else n_pass++;
    endtask

    task automatic test_deskew_err();
        int base;
        fill_rows(5000);
        dn.o_ready = 1'b1;
        skip_r = 1;
        skip_c = 2;
        base = got.size();
        send_rows(3, 6);
        skip_r = -1;
        skip_c = -1;
        idle(6);
        n_checks++; if (deskew_err !== 1'b1) $display("FAIL skew_flag: got %b expected 1", deskew_err); else n_pass++;
        n_checks++; if (got.size() - base != 3) $display("FAIL skew_pops: got %0d expected 3", got.size() - base); else n_pass++;
        n_checks++; if (row_count !== 16'd3) $display("FAIL skew_row_count: got %0d expected 3", row_count); else n_pass++;
        if (got.size() - base >= 3) begin
            n_checks++; if (got[base] !== row_in[0] || got[base + 2] !== row_in[2]) $display("FAIL skew_clean_rows: got %h %h expected %h %h", got[base], got[base + 2], row_in[0], row_in[2]); else n_pass++;
        end
        finish_tile("skew");
    endtask

    task automatic test_empty_tile();
        finish_tile("empty");
        n_checks++; if (row_count !== 16'd3) $display("FAIL empty_row_count_held: got %0d expected 3", row_count); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single_row();
        test_streaming();
        test_overflow();
        test_full_push_pop();
        test_relu();
        test_reset_mid_tile();
        test_deskew_err();
        test_empty_tile();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
